ftdi_tx_writer: RTL

FTDI_TX_WRITER -- requirements
Module: ftdi_tx_writer

---
 rtl/ftdi_tx_writer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ftdi_tx_writer.sv
// Buffers bytes from the laser receive path and writes them to the FTDI FIFO
// over the shared ADBUS, using a timed WR# strobe once the bus is granted.
module ftdi_tx_writer #(
    parameter int DEPTH       = 16,
    parameter int SETUP_CYC   = 2,
    parameter int WR_LOW_CYC  = 4,
    parameter int HOLD_CYC    = 2,
    parameter int RECOVER_CYC = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [7:0]             data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    input  logic                   txe,
    input  logic                   bus_grant,
    output logic                   bus_req,
    output logic [7:0]             adbus_out,
    output logic                   adbus_tri,
    output logic                   ftdi_wr,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int MAX_SW  = (SETUP_CYC > WR_LOW_CYC) ? SETUP_CYC : WR_LOW_CYC;
    localparam int MAX_HR  = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int MAX_CYC = (MAX_SW > MAX_HR) ? MAX_SW : MAX_HR;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    // Synchronizers and reset-release qualifier
    logic             txe_meta_q, txe_meta_d;
    logic             txe_s_q, txe_s_d;
    logic [1:0]       run_q, run_d;

    // Byte buffer
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             data_in_ready_q, data_in_ready_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic             pop;

    // Write sequencer
    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             bus_req_q, bus_req_d;
    logic             adbus_tri_q, adbus_tri_d;
    logic [7:0]       adbus_out_q, adbus_out_d;
    logic             ftdi_wr_q, ftdi_wr_d;

    always_comb begin
        txe_meta_d = txe;
        txe_s_d    = txe_meta_q;
        run_d      = {run_q[0], 1'b1};
    end

    // A dropped byte is one offered while the buffer was already full.
    always_comb begin
        push            = data_in_valid && data_in_ready_q;
        wr_ptr_d        = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d        = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d         = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        data_in_ready_d = (count_d < CNT_W'(DEPTH));
        overflow_d      = overflow_q || (data_in_valid && !data_in_ready_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            txe_meta_q      <= 1'b1;
            txe_s_q         <= 1'b1;
            run_q           <= 2'b00;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            data_in_ready_q <= 1'b1;
            overflow_q      <= 1'b0;
        end else begin
            txe_meta_q      <= txe_meta_d;
            txe_s_q         <= txe_s_d;
            run_q           <= run_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            data_in_ready_q <= data_in_ready_d;
            overflow_q      <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Each timed state loads (length - 1) on entry and leaves when the timer hits zero.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_q[1] && en && (count_q != '0) && !txe_s_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_grant) begin
                    state_d = ST_SETUP;
                    tmr_d   = TMR_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = ST_STROBE;
                    tmr_d   = TMR_W'(WR_LOW_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_STROBE: begin
                if (tmr_q == '0) begin
                    state_d = ST_HOLD;
                    tmr_d   = TMR_W'(HOLD_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = ST_RECOVER;
                    tmr_d   = TMR_W'(RECOVER_CYC - 1);
                    pop     = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_RECOVER: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // Bus outputs are a registered decode of the current state, so they trail it by one cycle.
    always_comb begin
        bus_req_d   = (state_q inside {ST_REQ, ST_SETUP, ST_STROBE, ST_HOLD});
        adbus_tri_d = (state_q inside {ST_SETUP, ST_STROBE, ST_HOLD});
        ftdi_wr_d   = (state_q != ST_STROBE);
        adbus_out_d = adbus_tri_d ? mem_q[rd_ptr_q] : 8'h00;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            bus_req_q   <= 1'b0;
            adbus_tri_q <= 1'b0;
            adbus_out_q <= 8'h00;
            ftdi_wr_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bus_req_q   <= bus_req_d;
            adbus_tri_q <= adbus_tri_d;
            adbus_out_q <= adbus_out_d;
            ftdi_wr_q   <= ftdi_wr_d;
        end
    end

    assign data_in_ready = data_in_ready_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign bus_req       = bus_req_q;
    assign adbus_tri     = adbus_tri_q;
    assign adbus_out     = adbus_out_q;
    assign ftdi_wr       = ftdi_wr_q;

endmodule
